// File: rtl/mem_arbiter.sv
// Arbitrates a single byte-wide synchronous RAM between an instruction fetch
// port (4-byte reads) and a load/store port (1/2/4-byte reads or writes).
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [1:0]        lsu_size,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_done,
    output logic [31:0]       lsu_rdata,
    input  logic              flush
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [2:0]        r_n, w_n;
    logic [2:0]        r_k, w_k;
    logic              r_is_lsu, w_is_lsu;
    logic              r_last_lsu, w_last_lsu;
    logic [31:0]       r_wdata, w_wdata;
    logic [31:0]       r_buf, w_buf;

    logic [ADDR_W-1:0] r_mem_a, w_mem_a;
    logic [7:0]        r_mem_dout, w_mem_dout;
    logic              r_mem_wr, w_mem_wr;
    logic              r_if_done, w_if_done;
    logic [31:0]       r_if_data, w_if_data;
    logic              r_lsu_done, w_lsu_done;
    logic [31:0]       r_lsu_rdata, w_lsu_rdata;

    logic              w_if_ok, w_gnt_lsu, w_gnt_if;
    logic [1:0]        w_cidx, w_nk;
    logic [31:0]       w_merged;
    logic [ADDR_W-1:0] w_next_addr;
    logic [2:0]        w_lsu_n;

    assign mem_a     = r_mem_a;
    assign mem_dout  = r_mem_dout;
    assign mem_wr    = r_mem_wr;
    assign if_done   = r_if_done;
    assign if_data   = r_if_data;
    assign lsu_done  = r_lsu_done;
    assign lsu_rdata = r_lsu_rdata;

    // Alternate when both request, but only if fetch is actually eligible.
    assign w_if_ok   = if_req & ~flush;
    assign w_gnt_lsu = lsu_req & ~(w_if_ok & r_last_lsu);
    assign w_gnt_if  = w_if_ok & ~w_gnt_lsu;

    assign w_nk        = 2'(r_k + 3'd1);
    assign w_cidx      = 2'(r_k - 3'd1);
    assign w_next_addr = r_addr + ADDR_W'(r_k + 3'd1);

    always_comb begin
        w_merged = r_buf;
        w_merged[8*w_cidx +: 8] = mem_din;
    end

    always_comb begin
        unique case (lsu_size)
            2'd0:    w_lsu_n = 3'd1;
            2'd1:    w_lsu_n = 3'd2;
            default: w_lsu_n = 3'd4;
        endcase
    end

    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_n         = r_n;
        w_k         = r_k;
        w_is_lsu    = r_is_lsu;
        w_last_lsu  = r_last_lsu;
        w_wdata     = r_wdata;
        w_buf       = r_buf;
        w_mem_a     = '0;
        w_mem_dout  = '0;
        w_mem_wr    = 1'b0;
        w_if_done   = 1'b0;
        w_lsu_done  = 1'b0;
        w_if_data   = r_if_data;
        w_lsu_rdata = r_lsu_rdata;

        unique case (r_state)
            IDLE: begin
                if (w_gnt_lsu) begin
                    w_is_lsu   = 1'b1;
                    w_last_lsu = 1'b1;
                    w_addr     = lsu_addr;
                    w_n        = w_lsu_n;
                    w_wdata    = lsu_wdata;
                    w_buf      = '0;
                    w_k        = '0;
                    w_mem_a    = lsu_addr;
                    if (lsu_we) begin
                        w_state    = WRITE;
                        w_mem_wr   = 1'b1;
                        w_mem_dout = lsu_wdata[7:0];
                    end else begin
                        w_state    = READ;
                    end
                end else if (w_gnt_if) begin
                    w_is_lsu   = 1'b0;
                    w_last_lsu = 1'b0;
                    w_addr     = if_addr;
                    w_n        = 3'd4;
                    w_buf      = '0;
                    w_k        = '0;
                    w_mem_a    = if_addr;
                    w_state    = READ;
                end
            end
            READ: begin
                if (flush && !r_is_lsu) begin
                    w_state = IDLE;
                end else begin
                    // r_k counts addresses issued; RAM data trails by one cycle.
                    if (r_k != 3'd0) begin
                        w_buf = w_merged;
                    end
                    if (r_k == r_n) begin
                        w_state = DONE;
                        if (r_is_lsu) begin
                            w_lsu_rdata = w_merged;
                            w_lsu_done  = 1'b1;
                        end else begin
                            w_if_data   = w_merged;
                            w_if_done   = 1'b1;
                        end
                    end else begin
                        w_k = r_k + 3'd1;
                        if ((r_k + 3'd1) < r_n) begin
                            w_mem_a = w_next_addr;
                        end
                    end
                end
            end
            WRITE: begin
                if ((r_k + 3'd1) < r_n) begin
                    w_k        = r_k + 3'd1;
                    w_mem_a    = w_next_addr;
                    w_mem_wr   = 1'b1;
                    w_mem_dout = r_wdata[8*w_nk +: 8];
                end else begin
                    w_state    = DONE;
                    w_lsu_done = 1'b1;
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_is_lsu    <= 1'b0;
            r_last_lsu  <= 1'b0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_mem_a     <= '0;
            r_mem_dout  <= '0;
            r_mem_wr    <= 1'b0;
            r_if_done   <= 1'b0;
            r_if_data   <= '0;
            r_lsu_done  <= 1'b0;
            r_lsu_rdata <= '0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_n         <= w_n;
            r_k         <= w_k;
            r_is_lsu    <= w_is_lsu;
            r_last_lsu  <= w_last_lsu;
            r_wdata     <= w_wdata;
            r_buf       <= w_buf;
            r_mem_a     <= w_mem_a;
            r_mem_dout  <= w_mem_dout;
            r_mem_wr    <= w_mem_wr;
            r_if_done   <= w_if_done;
            r_if_data   <= w_if_data;
            r_lsu_done  <= w_lsu_done;
            r_lsu_rdata <= w_lsu_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions against a
// byte RAM model, plus hand-timed arbitration, flush and reset sequences.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsu_req;
    logic        lsu_we;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        flush;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_a     (mem_a),
        .mem_wr    (mem_wr),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_data   (if_data),
        .lsu_req   (lsu_req),
        .lsu_we    (lsu_we),
        .lsu_addr  (lsu_addr),
        .lsu_size  (lsu_size),
        .lsu_wdata (lsu_wdata),
        .lsu_done  (lsu_done),
        .lsu_rdata (lsu_rdata),
        .flush     (flush)
    );

    always #5 clk_in = ~clk_in;

    // RAM model indexed by the low 16 address bits; one writer process.
    logic [7:0]  ram [0:65535];
    logic        pk_en = 1'b0;
    logic [15:0] pk_addr = '0;
    logic [7:0]  pk_data = '0;

    always @(posedge clk_in) begin
        if (pk_en) ram[pk_addr] <= pk_data;
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        mem_din <= ram[mem_a[15:0]];
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_if_data  = '0;
    logic [31:0] exp_lsu_data = '0;

    typedef struct {
        logic        lsu;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pk_addr = a;
        pk_data = d;
        pk_en   = 1'b1;
        tick();
        pk_en   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " mem_a"},     mem_a, 32'h0);
        chk({tag, " mem_dout"},  {24'h0, mem_dout}, 32'h0);
        chk({tag, " mem_wr"},    {31'h0, mem_wr}, 32'h0);
        chk({tag, " if_done"},   {31'h0, if_done}, 32'h0);
        chk({tag, " lsu_done"},  {31'h0, lsu_done}, 32'h0);
        chk({tag, " if_data"},   if_data, 32'h0);
        chk({tag, " lsu_rdata"}, lsu_rdata, 32'h0);
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int n;
        int dcyc;
        logic [31:0] wb;
        string tag;
        tag = $sformatf("v%0d", idx);
        if (!v.lsu)             n = 4;
        else if (v.size == 2'd0) n = 1;
        else if (v.size == 2'd1) n = 2;
        else                     n = 4;
        dcyc = v.we ? n + 1 : n + 2;
        if (v.lsu) begin
            lsu_req = 1'b1; lsu_we = v.we; lsu_addr = v.addr;
            lsu_size = v.size; lsu_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int j = 1; j <= dcyc; j++) begin
            tick();
            if (j <= n) begin
                chk({tag, " mem_a"}, mem_a, v.addr + 32'(j - 1));
                chk({tag, " mem_wr"}, {31'h0, mem_wr}, {31'h0, v.we});
                if (v.we) begin
                    wb = v.wdata >> (8 * (j - 1));
                    chk({tag, " mem_dout"}, {24'h0, mem_dout}, {24'h0, wb[7:0]});
                end
            end
            if (j < dcyc) begin
                chk({tag, " early if_done"}, {31'h0, if_done}, 32'h0);
                chk({tag, " early lsu_done"}, {31'h0, lsu_done}, 32'h0);
            end else begin
                if (v.lsu && !v.we) exp_lsu_data = v.exp_data;
                if (!v.lsu)         exp_if_data  = v.exp_data;
                chk({tag, " if_done"},  {31'h0, if_done},  {31'h0, ~v.lsu});
                chk({tag, " lsu_done"}, {31'h0, lsu_done}, {31'h0, v.lsu});
                chk({tag, " done mem_wr"}, {31'h0, mem_wr}, 32'h0);
                chk({tag, " done mem_a"}, mem_a, 32'h0);
                chk({tag, " if_data"},   if_data,   exp_if_data);
                chk({tag, " lsu_rdata"}, lsu_rdata, exp_lsu_data);
            end
        end
        tick();
        chk({tag, " post if_done"},  {31'h0, if_done},  32'h0);
        chk({tag, " post lsu_done"}, {31'h0, lsu_done}, 32'h0);
        if_req  = 1'b0;
        lsu_req = 1'b0;
        lsu_we  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_1000, 2'd0, 32'h0,          32'h0000_0013};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_3000, 2'd2, 32'h0,          32'h4433_2211};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_3002, 2'd1, 32'h0,          32'h0000_4433};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_3001, 2'd0, 32'h0,          32'h0000_0022};
        vecs[4]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 2'd0, 32'h0,          32'h0000_0080};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFF_FFFE, 2'd3, 32'h0,          32'h0201_807F};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_2001, 2'd1, 32'hAABB_CCDD,  32'h0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_3003, 2'd0, 32'hCAFE_BA77,  32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_3000, 2'd0, 32'h0,          32'h7733_2211};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_4000, 2'd2, 32'h1234_5678,  32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_4000, 2'd2, 32'h0,          32'h1234_5678};

        rst_in = 1'b1; if_req = 1'b0; if_addr = '0; lsu_req = 1'b0; lsu_we = 1'b0;
        lsu_addr = '0; lsu_size = '0; lsu_wdata = '0; flush = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_in = 1'b0;

        poke(16'h1000, 8'h13); poke(16'h1001, 8'h00);
        poke(16'h1002, 8'h00); poke(16'h1003, 8'h00);
        poke(16'h3000, 8'h11); poke(16'h3001, 8'h22);
        poke(16'h3002, 8'h33); poke(16'h3003, 8'h44);
        poke(16'hFFFE, 8'h7F); poke(16'hFFFF, 8'h80);
        poke(16'h0000, 8'h01); poke(16'h0001, 8'h02);
        poke(16'h2003, 8'h5A); poke(16'h5002, 8'hEE);

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i], i);
            if (i == 6) begin
                chk("ram 2001", {24'h0, ram[16'h2001]}, 32'hDD);
                chk("ram 2002", {24'h0, ram[16'h2002]}, 32'hCC);
                chk("ram 2003", {24'h0, ram[16'h2003]}, 32'h5A);
            end
        end

        // flush in IDLE blocks the fetch grant for that cycle only
        if_req = 1'b1; if_addr = 32'h1000; flush = 1'b1;
        tick();
        chk("idleflush C1 mem_a", mem_a, 32'h0);
        flush = 1'b0;
        tick();
        chk("idleflush C2 mem_a", mem_a, 32'h1000);
        for (int j = 3; j <= 7; j++) tick();
        chk("idleflush if_done", {31'h0, if_done}, 32'h1);
        exp_if_data = 32'h13;
        chk("idleflush if_data", if_data, exp_if_data);
        tick();
        if_req = 1'b0;

        // flush in C3 of a fetch with an LSU load pending
        if_req = 1'b1; if_addr = 32'h1000;
        tick();
        chk("flush C1 mem_a", mem_a, 32'h1000);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h3001; lsu_size = 2'd0;
        tick();
        tick();
        flush = 1'b1; if_req = 1'b0;
        tick();
        chk("flush C4 mem_a", mem_a, 32'h0);
        chk("flush C4 if_done", {31'h0, if_done}, 32'h0);
        chk("flush C4 if_data", if_data, exp_if_data);
        flush = 1'b0;
        tick();
        chk("flush C5 lsu mem_a", mem_a, 32'h3001);
        tick();
        chk("flush C6 if_done", {31'h0, if_done}, 32'h0);
        tick();
        chk("flush C7 lsu_done", {31'h0, lsu_done}, 32'h1);
        chk("flush C7 if_done", {31'h0, if_done}, 32'h0);
        exp_lsu_data = 32'h22;
        chk("flush C7 lsu_rdata", lsu_rdata, exp_lsu_data);
        chk("flush C7 if_data", if_data, exp_if_data);
        tick();
        lsu_req = 1'b0;

        // simultaneous requests after reset: LSU, fetch, LSU
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        exp_if_data = '0; exp_lsu_data = '0;
        if_req = 1'b1; if_addr = 32'h1000;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h3001; lsu_size = 2'd0;
        for (int j = 1; j <= 14; j++) begin
            tick();
            case (j)
                1:  chk("arb C1 mem_a lsu", mem_a, 32'h3001);
                3:  begin
                        chk("arb C3 lsu_done", {31'h0, lsu_done}, 32'h1);
                        chk("arb C3 lsu_rdata", lsu_rdata, 32'h22);
                    end
                4:  chk("arb C4 mem_a idle", mem_a, 32'h0);
                5:  chk("arb C5 mem_a fetch", mem_a, 32'h1000);
                10: begin
                        chk("arb C10 if_done", {31'h0, if_done}, 32'h1);
                        chk("arb C10 if_data", if_data, 32'h13);
                    end
                12: begin
                        chk("arb C12 mem_a lsu", mem_a, 32'h3001);
                        if_req = 1'b0; lsu_req = 1'b0;
                    end
                14: chk("arb C14 lsu_done", {31'h0, lsu_done}, 32'h1);
                default: ;
            endcase
        end
        tick();

        // reset in C2 of a 4-byte store
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h5000; lsu_size = 2'd2;
        lsu_wdata = 32'h0102_0304;
        tick();
        chk("rst C1 mem_wr", {31'h0, mem_wr}, 32'h1);
        chk("rst C1 mem_a", mem_a, 32'h5000);
        chk("rst C1 mem_dout", {24'h0, mem_dout}, 32'h04);
        tick();
        chk("rst C2 mem_a", mem_a, 32'h5001);
        chk("rst C2 mem_dout", {24'h0, mem_dout}, 32'h03);
        rst_in = 1'b1;
        tick();
        chk_reset_outputs("rst C3");
        rst_in = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0;
        for (int j = 4; j <= 8; j++) begin
            tick();
            chk("rst no lsu_done", {31'h0, lsu_done}, 32'h0);
        end
        chk("rst ram 5000", {24'h0, ram[16'h5000]}, 32'h04);
        chk("rst ram 5001", {24'h0, ram[16'h5001]}, 32'h03);
        chk("rst ram 5002", {24'h0, ram[16'h5002]}, 32'hEE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning width of all address ports.
REQ-002 SHALL have port clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports mem_din  input  8  RAM read byte; mem_dout  output  8  RAM write byte; mem_a  output  ADDR_W  RAM byte address; mem_wr  output  1  RAM write strobe, all outputs registered.
REQ-005 SHALL have ports if_req  input  1  fetch request; if_addr  input  ADDR_W  fetch address; if_done  output  1  fetch complete pulse; if_data  output  32  fetched word.
REQ-006 SHALL have ports lsu_req  input  1  LSU request; lsu_we  input  1  1=store; lsu_addr  input  ADDR_W; lsu_size  input  2  0=1B, 1=2B, 2/3=4B; lsu_wdata  input  32; lsu_done  output  1  complete pulse; lsu_rdata  output  32  load data.
REQ-007 SHALL have port flush  input  1  abort any fetch transaction (branch mispredict).

Function
REQ-008 SHALL share one byte-wide synchronous RAM between fetch (always 4B read) and LSU (1/2/4B read or write); RAM returns mem_din in cycle after mem_a presented.
REQ-009 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-010 IDLE: sample requests; on grant latch address, size N, port, write data; next state READ or WRITE; byte counter k=0.
REQ-011 Arbitration: both requesting -> LSU wins, unless last grant was LSU and if_req high, then fetch wins; single requester always granted.
REQ-012 Read, request seen in IDLE cycle C0: mem_a=addr+k in cycles C1..CN; byte from mem_din captured end of cycle C(k+2); done pulse in cycle C(N+2).
REQ-013 Write, request seen in C0: mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1 in cycles C1..CN; mem_wr=0 from C(N+1); lsu_done in C(N+1).
REQ-014 Little-endian: byte at addr+k -> data bits [8k+7:8k]; 1B/2B loads zero-extended in lsu_rdata.
REQ-015 Address increment wraps modulo 2^ADDR_W.
REQ-016 Done pulses exactly one cycle (state DONE); if_data/lsu_rdata valid in that cycle and held until next done on same port.
REQ-017 No grant in DONE cycle; requester drops req in cycle after seeing done; next grant earliest in cycle after DONE.
REQ-018 Transactions are never preempted; a request arriving mid-transaction waits.
REQ-019 In IDLE/DONE: mem_wr=0, mem_a=0, mem_dout=0.
REQ-020 flush high during a fetch READ/DONE: next cycle IDLE, if_done not (further) asserted, if_data unchanged; flush high in IDLE suppresses fetch grant that cycle only.
REQ-021 flush SHALL NOT affect LSU transactions.
REQ-022 Requests with mem_wr high SHALL only originate from LSU store; fetch never writes.

Reset
REQ-023 rst_in high at rising edge: state IDLE, mem_a=0, mem_dout=0, mem_wr=0, if_done=0, lsu_done=0, if_data=0, lsu_rdata=0, last grant=fetch.
REQ-024 Reset mid-transaction SHALL abort it without any done pulse; partial write bytes already written remain.

Verification
REQ-025 Fetch only, if_addr=0x1000, RAM 0x1000..0x1003 = 13,00,00,00 -> mem_a 0x1000..0x1003 in C1..C4, if_done in C6, if_data=0x00000013.
REQ-026 LSU store lsu_size=1, addr=0x2001, wdata=0xAABBCCDD -> mem_wr=1 with (0x2001,DD),(0x2002,CC) in C1..C2, lsu_done in C3, RAM 0x2001=DD, 0x2002=CC, 0x2003 untouched.
REQ-027 if_req and lsu_req rise same cycle after reset -> LSU granted first; fetch granted in cycle after LSU DONE; then with both held, LSU/fetch alternate.
REQ-028 LSU 1B load addr=0xFFFFFFFF (RAM=0x80) -> lsu_rdata=0x00000080; 4B load at 0xFFFFFFFE reads bytes from 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1.
REQ-029 flush asserted in C3 of fetch -> IDLE in C4, no if_done, if_data keeps prior value; a pending lsu_req granted in C4.
REQ-030 rst_in asserted in C2 of 4B store -> mem_wr=0 in C3, no lsu_done, all outputs at reset values.
